// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Register 31 is the zero register (XZR): writes are accepted but discarded.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    WB_EX  = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_grant remembers the most recent winner
// and only moves when a grant is actually issued.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  wb_src_e last_grant_q;
  wb_src_e last_grant_d;

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == WB_MEM) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      last_grant_d = WB_EX;
    end else if (grant[1]) begin
      last_grant_d = WB_MEM;
    end
  end

  // Resetting to WB_MEM lets requester 0 win the first conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= WB_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between EX and MEM writeback and keeps a
// per-register pending-write scoreboard that decode uses to stall on RAW hazards.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            wb_valid,
  output logic [1:0]            wb_ready,
  input  reg_addr_t             wb_addr0,
  input  reg_addr_t             wb_addr1,
  input  logic [DATA_WIDTH-1:0] wb_data0,
  input  logic [DATA_WIDTH-1:0] wb_data1,
  output logic                  rf_wr_en,
  output reg_addr_t             rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic                  issue_valid,
  input  reg_addr_t             issue_addr,
  output logic                  issue_stall,
  input  reg_addr_t             rs_addr1,
  input  reg_addr_t             rs_addr2,
  output logic [1:0]            rs_busy,
  output logic                  sb_error
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]            grant;
  logic                  xfer;
  reg_addr_t             xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  issue_inc;
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;

  logic                  rf_wr_en_q,   rf_wr_en_d;
  reg_addr_t             rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  sb_error_q,   sb_error_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wb_valid),
    .grant (grant)
  );

  assign wb_ready = grant;

  // Hazard outputs look at registered counts, so a same-cycle commit does not unbusy.
  assign issue_stall = (issue_addr != ZERO_REG) && (cnt_q[issue_addr] == CNT_MAX);
  assign rs_busy[0]  = (rs_addr1 != ZERO_REG) && (cnt_q[rs_addr1] != '0);
  assign rs_busy[1]  = (rs_addr2 != ZERO_REG) && (cnt_q[rs_addr2] != '0);

  always_comb begin
    xfer      = |(wb_valid & grant);
    xfer_addr = grant[1] ? wb_addr1 : wb_addr0;
    xfer_data = grant[1] ? wb_data1 : wb_data0;
    issue_inc = issue_valid && !issue_stall && (issue_addr != ZERO_REG);
    inc_vec   = issue_inc ? (NUM_REGS'(1) << issue_addr) : '0;
    dec_vec   = (xfer && (xfer_addr != ZERO_REG)) ? (NUM_REGS'(1) << xfer_addr) : '0;
  end

  always_comb begin
    rf_wr_en_d   = xfer && (xfer_addr != ZERO_REG);
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    if (rf_wr_en_d) begin
      rf_wr_addr_d = xfer_addr;
      rf_wr_data_d = xfer_data;
    end
  end

  // A commit to an idle register is a pipeline bug: hold the count at zero and flag it.
  always_comb begin
    sb_error_d = sb_error_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] != CNT_MAX) begin
          cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
        end
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) begin
          sb_error_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      sb_error_q   <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      sb_error_q   <= sb_error_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign sb_error   = sb_error_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a per-cycle
// behavioural model of arbitration, write latency and the pending-write counts.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_valid;
  logic [1:0]  wb_ready;
  logic [4:0]  wb_addr0, wb_addr1;
  logic [63:0] wb_data0, wb_data1;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_stall;
  logic [4:0]  rs_addr1, rs_addr2;
  logic [1:0]  rs_busy;
  logic        sb_error;

  int compared   = 0;
  int mismatched = 0;

  // Model state: counts as plain integers, winner of the last grant as an index.
  int          cnt_m [32];
  int          last_m;
  bit          err_m;
  bit          en_m;
  logic [4:0]  addr_m;
  logic [63:0] data_m;
  bit          known = 1'b0;

  logic [1:0]  seen_ready;
  logic        seen_stall;
  logic [1:0]  seen_busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(64), .CNT_WIDTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr0    (wb_addr0),
    .wb_addr1    (wb_addr1),
    .wb_data0    (wb_data0),
    .wb_data1    (wb_data1),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_stall (issue_stall),
    .rs_addr1    (rs_addr1),
    .rs_addr2    (rs_addr2),
    .rs_busy     (rs_busy),
    .sb_error    (sb_error)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks combinational outputs mid-cycle,
  // advances the model and checks registered outputs just after the edge.
  task automatic applyStimulus(input logic rst, input logic [1:0] v,
                               input logic [4:0] a0, input logic [63:0] d0,
                               input logic [4:0] a1, input logic [63:0] d1,
                               input logic iv, input logic [4:0] ia,
                               input logic [4:0] r1, input logic [4:0] r2);
    int          win;
    int          delta [32];
    logic [1:0]  exp_ready;
    logic        exp_stall;
    logic [1:0]  exp_busy;
    logic [4:0]  waddr;
    bit          inc;
    reset = rst; wb_valid = v; wb_addr0 = a0; wb_data0 = d0; wb_addr1 = a1; wb_data1 = d1;
    issue_valid = iv; issue_addr = ia; rs_addr1 = r1; rs_addr2 = r2;
    @(negedge clk);
    win = -1;
    if (v == 2'b01) win = 0;
    else if (v == 2'b10) win = 1;
    else if (v == 2'b11) win = (last_m == 1) ? 0 : 1;
    exp_ready   = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
    exp_stall   = (ia != 5'd31) && (cnt_m[ia] == 3);
    exp_busy[0] = (r1 != 5'd31) && (cnt_m[r1] != 0);
    exp_busy[1] = (r2 != 5'd31) && (cnt_m[r2] != 0);
    seen_ready = wb_ready;
    seen_stall = issue_stall;
    seen_busy  = rs_busy;
    if (known) begin
      checkOutput("wb_ready", wb_ready, exp_ready);
      checkOutput("issue_stall", issue_stall, exp_stall);
      checkOutput("rs_busy", rs_busy, exp_busy);
    end
    if (rst) begin
      foreach (cnt_m[r]) cnt_m[r] = 0;
      last_m = 1; err_m = 0; en_m = 0; addr_m = '0; data_m = '0;
      known = 1'b1;
    end else begin
      foreach (delta[r]) delta[r] = 0;
      inc = iv && !exp_stall && (ia != 5'd31);
      if (inc) delta[ia] = delta[ia] + 1;
      en_m = 1'b0;
      if (win >= 0) begin
        last_m = win;
        waddr  = (win == 1) ? a1 : a0;
        if (waddr != 5'd31) begin
          en_m = 1'b1; addr_m = waddr; data_m = (win == 1) ? d1 : d0;
          if (cnt_m[waddr] == 0 && !(inc && ia == waddr)) err_m = 1'b1;
          delta[waddr] = delta[waddr] - 1;
        end
      end
      foreach (cnt_m[r]) begin
        cnt_m[r] = cnt_m[r] + delta[r];
        if (cnt_m[r] < 0) cnt_m[r] = 0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rf_wr_en", rf_wr_en, en_m);
    if (en_m) begin
      checkOutput("rf_wr_addr", rf_wr_addr, addr_m);
      checkOutput("rf_wr_data", rf_wr_data, data_m);
    end
    checkOutput("sb_error", sb_error, err_m);
  endtask

  task automatic idle(input logic [4:0] ia, input logic [4:0] r1);
    applyStimulus(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, ia, r1, 5'd0);
  endtask

  task automatic issue(input logic [4:0] ia);
    applyStimulus(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, ia, ia, 5'd0);
  endtask

  function automatic logic [4:0] pickReg();
    int k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  initial begin
    logic [1:0]  exp_rdy_seq [4];
    logic [4:0]  exp_addr_seq [4];
    logic [1:0]  rv;
    logic [4:0]  ra0, ra1;
    logic [63:0] rd0, rd1;
    bit          held0, held1;
    exp_rdy_seq  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr_seq = '{5'd1, 5'd2, 5'd1, 5'd2};
    foreach (cnt_m[r]) cnt_m[r] = 0;
    last_m = 1; err_m = 0; en_m = 0; addr_m = '0; data_m = '0;

    applyStimulus(1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("reset_rf_wr_en", rf_wr_en, 1'b0);
    checkOutput("reset_rf_wr_addr", rf_wr_addr, 5'd0);
    checkOutput("reset_rf_wr_data", rf_wr_data, 64'd0);
    checkOutput("reset_sb_error", sb_error, 1'b0);

    // Single transfer with one-cycle write latency.
    issue(5'd5);
    applyStimulus(1'b0, 2'b01, 5'd5, 64'hDEAD, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("t1_ready", seen_ready, 2'b01);
    checkOutput("t1_wr_en", rf_wr_en, 1'b1);
    checkOutput("t1_wr_addr", rf_wr_addr, 5'd5);
    checkOutput("t1_wr_data", rf_wr_data, 64'hDEAD);
    idle(5'd0, 5'd0);
    checkOutput("t1_wr_en_drop", rf_wr_en, 1'b0);

    // Conflict after reset alternates starting with requester 0.
    applyStimulus(1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    issue(5'd1); issue(5'd1); issue(5'd2); issue(5'd2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b11, 5'd1, 64'h100 + 64'(i), 5'd2, 64'h200 + 64'(i),
                    1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("t2_ready", seen_ready, exp_rdy_seq[i]);
      checkOutput("t2_wr_addr", rf_wr_addr, exp_addr_seq[i]);
    end

    // XZR writes are accepted but never reach the register file.
    applyStimulus(1'b0, 2'b10, 5'd0, 64'd0, 5'd31, 64'h1234, 1'b0, 5'd0, 5'd31, 5'd31);
    checkOutput("t3_ready", seen_ready, 2'b10);
    checkOutput("t3_wr_en", rf_wr_en, 1'b0);
    checkOutput("t3_busy31", seen_busy, 2'b00);

    // Scoreboard saturation on reg 7 and drain by commits.
    issue(5'd7); issue(5'd7); issue(5'd7);
    idle(5'd7, 5'd7);
    checkOutput("t4_stall", seen_stall, 1'b1);
    checkOutput("t4_busy", seen_busy[0], 1'b1);
    applyStimulus(1'b0, 2'b01, 5'd7, 64'h77, 5'd0, 64'd0, 1'b0, 5'd7, 5'd7, 5'd0);
    idle(5'd7, 5'd7);
    checkOutput("t4_stall_clear", seen_stall, 1'b0);
    applyStimulus(1'b0, 2'b01, 5'd7, 64'h78, 5'd0, 64'd0, 1'b0, 5'd7, 5'd7, 5'd0);
    applyStimulus(1'b0, 2'b01, 5'd7, 64'h79, 5'd0, 64'd0, 1'b0, 5'd7, 5'd7, 5'd0);
    idle(5'd7, 5'd7);
    checkOutput("t4_busy_clear", seen_busy[0], 1'b0);

    // Same-cycle issue and commit, then a commit to an idle register.
    issue(5'd9);
    applyStimulus(1'b0, 2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd9);
    checkOutput("t5_busy9", seen_busy[0], 1'b1);
    checkOutput("t5_no_error", sb_error, 1'b0);
    applyStimulus(1'b0, 2'b01, 5'd4, 64'h44, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("t5_error", sb_error, 1'b1);
    idle(5'd0, 5'd0);
    checkOutput("t5_error_sticky", sb_error, 1'b1);

    // Reset during traffic clears everything and restores requester 0 priority.
    issue(5'd3); issue(5'd6);
    applyStimulus(1'b1, 2'b11, 5'd10, 64'hA, 5'd11, 64'hB, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("t6_wr_en", rf_wr_en, 1'b0);
    checkOutput("t6_sb_error", sb_error, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'(i), 5'(i), 5'(31 - i));
      checkOutput("t6_busy", seen_busy, 2'b00);
    end
    applyStimulus(1'b0, 2'b11, 5'd12, 64'hC, 5'd13, 64'hD, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("t6_first_winner", seen_ready, 2'b01);

    // Random traffic; a requester keeps its addr/data while waiting for ready.
    held0 = 0; held1 = 0; rv = 2'b00;
    ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int n = 0; n < 500; n++) begin
      if (!held0) begin
        rv[0] = 1'($urandom_range(0, 1)); ra0 = pickReg(); rd0 = {$urandom, $urandom};
      end
      if (!held1) begin
        rv[1] = 1'($urandom_range(0, 1)); ra1 = pickReg(); rd1 = {$urandom, $urandom};
      end
      applyStimulus(1'($urandom_range(0, 63) == 0), rv, ra0, rd0, ra1, rd1,
                    1'($urandom_range(0, 1)), pickReg(), pickReg(), pickReg());
      held0 = rv[0] && !seen_ready[0];
      held1 = rv[1] && !seen_ready[1];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
